// File: rtl/sd_spi_pkg.sv
// -----------------------------------------------------------------------------
// sd_spi_pkg
// Shared types and constants for the microSD SPI-mode command sequencer:
//   - sequencer state encoding and post-gap dispatch kinds
//   - command indices, fixed arguments and frame CRC bytes
//   - error codes reported on err_code
//   - idle (0xFF) and start-of-data token (0xFE) bytes
// Helper functions build the 32-bit argument and CRC byte for a command.
// -----------------------------------------------------------------------------
package sd_spi_pkg;

  typedef enum logic [3:0] {
    ST_DUMMY,   // init clocks with chip select high
    ST_CMD,     // six frame bytes
    ST_R1,      // poll for R1 (bit 7 clear)
    ST_EXTRA,   // trailing R7 bytes after CMD8
    ST_TOKEN,   // poll for start-of-data token
    ST_DATA,    // 512 payload bytes
    ST_CRC,     // two data CRC bytes, discarded
    ST_GAP,     // chip select high, one 0xFF byte
    ST_IDLE,    // initialised, waiting for rd_req
    ST_ERR      // sticky init failure
  } state_e;

  // What the gap byte leads into when no error is pending.
  typedef enum logic [1:0] {
    POST_CMD,        // issue next_idx as the next command
    POST_INIT_DONE,  // card ready, enter IDLE with init_done
    POST_READ_DONE   // block read complete, strobe rd_done
  } post_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_R1_TIMEOUT = 3'd1,
    ERR_CMD0       = 3'd2,
    ERR_CMD8       = 3'd3,
    ERR_ACMD41     = 3'd4,
    ERR_CMD17      = 3'd5,
    ERR_TOKEN      = 3'd6
  } err_e;

  localparam logic [5:0] IDX_CMD0   = 6'd0;
  localparam logic [5:0] IDX_CMD8   = 6'd8;
  localparam logic [5:0] IDX_CMD17  = 6'd17;
  localparam logic [5:0] IDX_ACMD41 = 6'd41;
  localparam logic [5:0] IDX_CMD55  = 6'd55;

  localparam logic [7:0] CRC_CMD0    = 8'h95;
  localparam logic [7:0] CRC_CMD8    = 8'h87;
  localparam logic [7:0] CRC_DEFAULT = 8'h01;

  localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
  localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;  // HCS set

  localparam logic [7:0] BYTE_IDLE  = 8'hFF;
  localparam logic [7:0] BYTE_TOKEN = 8'hFE;
  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_READY   = 8'h00;
  localparam logic [7:0] CMD8_ECHO  = 8'hAA;

  function automatic logic [31:0] cmd_arg(input logic [5:0] idx, input logic [31:0] addr);
    logic [31:0] a;
    a = 32'h0;
    if (idx == IDX_CMD8)        a = ARG_CMD8;
    else if (idx == IDX_ACMD41) a = ARG_ACMD41;
    else if (idx == IDX_CMD17)  a = addr;
    return a;
  endfunction

  // Only CMD0 and CMD8 are checked by the card in SPI mode; others get a dummy CRC with stop bit.
  function automatic logic [7:0] cmd_crc(input logic [5:0] idx);
    logic [7:0] c;
    c = CRC_DEFAULT;
    if (idx == IDX_CMD0)      c = CRC_CMD0;
    else if (idx == IDX_CMD8) c = CRC_CMD8;
    return c;
  endfunction

endpackage

// File: rtl/sd_cmd_frame_mux.sv
// -----------------------------------------------------------------------------
// sd_cmd_frame_mux
// Combinational selector for one byte of a 6-byte SPI command frame:
//   {0x40|idx, arg[31:24], arg[23:16], arg[15:8], arg[7:0], crc}
// Ports:
//   idx_i   [5:0]  command index
//   arg_i   [31:0] command argument
//   sel_i   [2:0]  byte position 0..5 (6/7 return 0xFF)
//   byte_o  [7:0]  selected frame byte
// -----------------------------------------------------------------------------
module sd_cmd_frame_mux
  import sd_spi_pkg::*;
(
  input  logic [5:0]  idx_i,
  input  logic [31:0] arg_i,
  input  logic [2:0]  sel_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = BYTE_IDLE;
    unique case (sel_i)
      3'd0:    byte_o = {2'b01, idx_i};
      3'd1:    byte_o = arg_i[31:24];
      3'd2:    byte_o = arg_i[23:16];
      3'd3:    byte_o = arg_i[15:8];
      3'd4:    byte_o = arg_i[7:0];
      3'd5:    byte_o = cmd_crc(idx_i);
      default: byte_o = BYTE_IDLE;
    endcase
  end

endmodule

// File: rtl/sd_spi_cmd_seq.sv
// -----------------------------------------------------------------------------
// sd_spi_cmd_seq
// Command sequencer in front of an SPI byte engine. After reset it runs SD
// SPI-mode initialisation (dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop) and then
// serves single-block CMD17 reads. Owns chip select and every byte issued.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   rd_req, rd_addr    block read request and block address
//   rd_busy            read in progress
//   rd_data, rd_valid  payload byte stream (512 strobes per block)
//   rd_done            one-cycle end-of-read strobe (success or error)
//   init_done          card initialised
//   err, err_code      error flag and cause
//   spi_en, spi_tx     byte start pulse and byte to send
//   spi_rx, spi_done   received byte and transfer-complete pulse
//   spi_cs_n           card chip select, active-low
// -----------------------------------------------------------------------------
module sd_spi_cmd_seq
  import sd_spi_pkg::*;
#(
  parameter int INIT_DUMMY_BYTES = 10,
  parameter int RESP_TIMEOUT     = 8,
  parameter int ACMD41_RETRIES   = 1000,
  parameter int TOKEN_TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_done,
  output logic        init_done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        spi_en,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_done,
  output logic        spi_cs_n
);

  localparam logic [9:0]  DUMMY_LAST = 10'(INIT_DUMMY_BYTES - 1);
  localparam logic [12:0] R1_LAST    = 13'(RESP_TIMEOUT - 1);
  localparam logic [12:0] TOKEN_LAST = 13'(TOKEN_TIMEOUT - 1);
  localparam logic [9:0]  RETRY_LAST = 10'(ACMD41_RETRIES - 1);
  localparam logic [9:0]  DATA_LAST  = 10'd511;

  state_e      state_q, state_d;
  post_e       post_q, post_d;
  err_e        pend_q, pend_d;
  logic [5:0]  cmd_idx_q, cmd_idx_d;
  logic [5:0]  next_idx_q, next_idx_d;
  logic [31:0] addr_q, addr_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [12:0] poll_q, poll_d;
  logic [9:0]  retry_q, retry_d;
  logic        inflight_q, inflight_d;
  logic        spi_en_q, spi_en_d;
  logic [7:0]  spi_tx_q, spi_tx_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_busy_q, rd_busy_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_done_q, rd_done_d;
  logic        init_done_q, init_done_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;

  logic        issue;
  logic [7:0]  issue_byte;
  logic [7:0]  frame_byte;

  sd_cmd_frame_mux u_frame (
    .idx_i  (cmd_idx_q),
    .arg_i  (cmd_arg(cmd_idx_q, addr_q)),
    .sel_i  (cnt_q[2:0]),
    .byte_o (frame_byte)
  );

  always_comb begin
    state_d     = state_q;
    post_d      = post_q;
    pend_d      = pend_q;
    cmd_idx_d   = cmd_idx_q;
    next_idx_d  = next_idx_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    poll_d      = poll_q;
    retry_d     = retry_q;
    inflight_d  = inflight_q;
    spi_en_d    = 1'b0;
    spi_tx_d    = spi_tx_q;
    cs_n_d      = cs_n_q;
    rd_busy_d   = rd_busy_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_done_d   = 1'b0;
    init_done_d = init_done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    issue       = 1'b0;
    issue_byte  = BYTE_IDLE;

    // Every byte-moving state follows the same rhythm: issue one byte when
    // nothing is in flight, then act on spi_done. State and chip-select changes
    // are only made on spi_done, so cs_n never moves mid-byte.
    if (inflight_q && spi_done) inflight_d = 1'b0;

    unique case (state_q)
      ST_DUMMY: begin
        if (!inflight_q) issue = 1'b1;
        else if (spi_done) begin
          if (cnt_q == DUMMY_LAST) begin
            cnt_d     = '0;
            retry_d   = '0;
            cmd_idx_d = IDX_CMD0;
            cs_n_d    = 1'b0;
            state_d   = ST_CMD;
          end else cnt_d = cnt_q + 10'd1;
        end
      end

      ST_CMD: begin
        if (!inflight_q) begin
          issue      = 1'b1;
          issue_byte = frame_byte;
        end else if (spi_done) begin
          if (cnt_q == 10'd5) begin
            cnt_d   = '0;
            poll_d  = '0;
            state_d = ST_R1;
          end else cnt_d = cnt_q + 10'd1;
        end
      end

      ST_R1: begin
        if (!inflight_q) issue = 1'b1;
        else if (spi_done) begin
          if (spi_rx[7]) begin
            if (poll_q == R1_LAST) begin
              pend_d  = ERR_R1_TIMEOUT;
              cs_n_d  = 1'b1;
              state_d = ST_GAP;
            end else poll_d = poll_q + 13'd1;
          end else begin
            case (cmd_idx_q)
              IDX_CMD0: begin
                if (spi_rx != R1_IDLE) pend_d = ERR_CMD0;
                post_d     = POST_CMD;
                next_idx_d = IDX_CMD8;
                cs_n_d     = 1'b1;
                state_d    = ST_GAP;
              end
              IDX_CMD8: begin
                if (spi_rx == R1_IDLE) begin
                  cnt_d   = '0;
                  state_d = ST_EXTRA;
                end else begin
                  pend_d  = ERR_CMD8;
                  cs_n_d  = 1'b1;
                  state_d = ST_GAP;
                end
              end
              IDX_CMD55: begin
                post_d     = POST_CMD;
                next_idx_d = IDX_ACMD41;
                cs_n_d     = 1'b1;
                state_d    = ST_GAP;
              end
              IDX_ACMD41: begin
                cs_n_d     = 1'b1;
                state_d    = ST_GAP;
                post_d     = POST_CMD;
                next_idx_d = IDX_CMD55;
                if (spi_rx == R1_READY) post_d = POST_INIT_DONE;
                else if (spi_rx == R1_IDLE && retry_q != RETRY_LAST) retry_d = retry_q + 10'd1;
                else pend_d = ERR_ACMD41;
              end
              default: begin
                if (spi_rx == R1_READY) begin
                  poll_d  = '0;
                  state_d = ST_TOKEN;
                end else begin
                  pend_d  = ERR_CMD17;
                  cs_n_d  = 1'b1;
                  state_d = ST_GAP;
                end
              end
            endcase
          end
        end
      end

      ST_EXTRA: begin
        if (!inflight_q) issue = 1'b1;
        else if (spi_done) begin
          if (cnt_q == 10'd3) begin
            // Last R7 byte must echo the check pattern sent in the CMD8 argument.
            if (spi_rx != CMD8_ECHO) pend_d = ERR_CMD8;
            post_d     = POST_CMD;
            next_idx_d = IDX_CMD55;
            cs_n_d     = 1'b1;
            state_d    = ST_GAP;
          end else cnt_d = cnt_q + 10'd1;
        end
      end

      ST_TOKEN: begin
        if (!inflight_q) issue = 1'b1;
        else if (spi_done) begin
          if (spi_rx == BYTE_TOKEN) begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end else if (spi_rx == BYTE_IDLE && poll_q != TOKEN_LAST) begin
            poll_d = poll_q + 13'd1;
          end else begin
            pend_d  = ERR_TOKEN;
            cs_n_d  = 1'b1;
            state_d = ST_GAP;
          end
        end
      end

      ST_DATA: begin
        if (!inflight_q) issue = 1'b1;
        else if (spi_done) begin
          rd_valid_d = 1'b1;
          rd_data_d  = spi_rx;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = ST_CRC;
          end else cnt_d = cnt_q + 10'd1;
        end
      end

      ST_CRC: begin
        if (!inflight_q) issue = 1'b1;
        else if (spi_done) begin
          if (cnt_q == 10'd1) begin
            post_d  = POST_READ_DONE;
            cs_n_d  = 1'b1;
            state_d = ST_GAP;
          end else cnt_d = cnt_q + 10'd1;
        end
      end

      ST_GAP: begin
        if (!inflight_q) issue = 1'b1;
        else if (spi_done) begin
          if (pend_q != ERR_NONE) begin
            err_d      = 1'b1;
            err_code_d = pend_q;
            pend_d     = ERR_NONE;
            if (cmd_idx_q == IDX_CMD17) begin
              rd_done_d = 1'b1;
              rd_busy_d = 1'b0;
              state_d   = ST_IDLE;
            end else begin
              init_done_d = 1'b0;
              state_d     = ST_ERR;
            end
          end else begin
            unique case (post_q)
              POST_CMD: begin
                cmd_idx_d = next_idx_q;
                cnt_d     = '0;
                cs_n_d    = 1'b0;
                state_d   = ST_CMD;
              end
              POST_INIT_DONE: begin
                init_done_d = 1'b1;
                state_d     = ST_IDLE;
              end
              default: begin
                rd_done_d = 1'b1;
                rd_busy_d = 1'b0;
                state_d   = ST_IDLE;
              end
            endcase
          end
        end
      end

      ST_IDLE: begin
        // rd_done_q guard drops a request that coincides with the end strobe.
        if (rd_req && init_done_q && !rd_busy_q && !rd_done_q) begin
          addr_d     = rd_addr;
          rd_busy_d  = 1'b1;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          cmd_idx_d  = IDX_CMD17;
          cnt_d      = '0;
          cs_n_d     = 1'b0;
          state_d    = ST_CMD;
        end
      end

      default: begin
        state_d = ST_ERR;
      end
    endcase

    if (issue) begin
      spi_en_d   = 1'b1;
      spi_tx_d   = issue_byte;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_DUMMY;
      post_q      <= POST_CMD;
      pend_q      <= ERR_NONE;
      cmd_idx_q   <= IDX_CMD0;
      next_idx_q  <= IDX_CMD0;
      addr_q      <= '0;
      cnt_q       <= '0;
      poll_q      <= '0;
      retry_q     <= '0;
      inflight_q  <= 1'b0;
      spi_en_q    <= 1'b0;
      spi_tx_q    <= BYTE_IDLE;
      cs_n_q      <= 1'b1;
      rd_busy_q   <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      post_q      <= post_d;
      pend_q      <= pend_d;
      cmd_idx_q   <= cmd_idx_d;
      next_idx_q  <= next_idx_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      poll_q      <= poll_d;
      retry_q     <= retry_d;
      inflight_q  <= inflight_d;
      spi_en_q    <= spi_en_d;
      spi_tx_q    <= spi_tx_d;
      cs_n_q      <= cs_n_d;
      rd_busy_q   <= rd_busy_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_done_q   <= rd_done_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign spi_en    = spi_en_q;
  assign spi_tx    = spi_tx_q;
  assign spi_cs_n  = cs_n_q;
  assign rd_busy   = rd_busy_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_done   = rd_done_q;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
